risc_core_hs: RTL and testbench

Parametrised multi-cycle accumulator CPU, the successor to the 8-bit `risc` top. It executes the same eight-opcode instruction set, with a configurable address width. It replaces the fixed eight-phase sequencer with a state machine that talks to a single unified memory over a req/ack handshake, so memory may insert any number of wait states. It sits between the system clock/reset and an external memory or bus adapter.

---
 rtl/risc_core_hs_pkg.sv | 31 +++
 rtl/risc_core_hs_alu.sv | 28 ++
 rtl/risc_core_hs.sv | 155 +++++++++++++++
 tb/tb_risc_core_hs.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_core_hs_pkg.sv
// Shared types for the risc_core_hs accumulator CPU: opcodes, sequencer states
// and the opcode-class helper used by the decoder.
package risc_pkg;

  localparam int OPC_WIDTH = 3;

  typedef enum logic [OPC_WIDTH-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MEM,
    EXEC,
    HALTED
  } state_t;

  // Opcodes that need a data-memory access between DECODE and EXEC.
  function automatic logic is_mem_op(input opcode_t opc);
    return (opc == ADD) || (opc == AND) || (opc == XOR) || (opc == LDA) || (opc == STO);
  endfunction

endpackage

// File: rtl/risc_core_hs_alu.sv
// Combinational accumulator ALU. Non-arithmetic opcodes pass AC through
// unchanged, so EXEC can always load the result back into AC.
module risc_core_alu
  import risc_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  opcode_t           opcode,
  input  logic [DWIDTH-1:0] ac,
  input  logic [DWIDTH-1:0] operand,
  output logic [DWIDTH-1:0] result,
  output logic              ac_zero
);

  always_comb begin
    result = ac;
    case (opcode)
      ADD:     result = ac + operand;
      AND:     result = ac & operand;
      XOR:     result = ac ^ operand;
      LDA:     result = operand;
      default: result = ac;
    endcase
  end

  assign ac_zero = (ac == '0);

endmodule

// File: rtl/risc_core_hs.sv
// Multi-cycle accumulator CPU with a req/ack unified memory port.
// Optional retired-instruction counter enabled by RISC_CORE_HS_PERF_EN.
//
// state  | meaning
// FETCH  | raise read of M[PC]; on ack latch IR, PC+1
// DECODE | pick MEM for ADD/AND/XOR/LDA/STO, else EXEC
// MEM    | read operand or write AC at IR address
// EXEC   | update AC/PC, retire; HLT goes to HALTED
// HALTED | idle with halt=1 until reset
module risc_core_hs
  import risc_pkg::*;
#(
  parameter  int                AWIDTH   = 5,
  parameter  logic [AWIDTH-1:0] RESET_PC = '0,
  localparam int                DWIDTH   = AWIDTH + 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halt,
  output logic [15:0]       instr_cnt
);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ac_q, ac_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [DWIDTH-1:0] opnd_q, opnd_d;
  logic              req_d, we_d, halt_d, retire;
  logic [AWIDTH-1:0] addr_d;
  logic [DWIDTH-1:0] wdata_d;
  logic [DWIDTH-1:0] alu_result;
  logic              ac_zero;
  opcode_t           opc;
  logic [AWIDTH-1:0] opa;
  logic              hs;

  assign opc = opcode_t'(ir_q[DWIDTH-1 -: OPC_WIDTH]);
  assign opa = ir_q[AWIDTH-1:0];
  assign hs  = mem_req && mem_ack;

  risc_core_alu #(.DWIDTH(DWIDTH)) u_alu (
    .opcode  (opc),
    .ac      (ac_q),
    .operand (opnd_q),
    .result  (alu_result),
    .ac_zero (ac_zero)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    halt_d  = halt;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (hs) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = DECODE;
        end else if (!mem_req) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = pc_q;
          wdata_d = ac_q;
        end
      end
      DECODE: state_d = is_mem_op(opc) ? MEM : EXEC;
      MEM: begin
        // Request stays idle for a cycle after each ack, so accesses never abut.
        if (hs) begin
          if (!mem_we) opnd_d = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = EXEC;
        end else if (!mem_req) begin
          req_d   = 1'b1;
          we_d    = (opc == STO);
          addr_d  = opa;
          wdata_d = ac_q;
        end
      end
      EXEC: begin
        retire = 1'b1;
        ac_d   = alu_result;
        if (opc == SKZ && ac_zero) pc_d = pc_q + 1'b1;
        if (opc == JMP) pc_d = opa;
        if (opc == HLT) begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ac_q      <= '0;
      ir_q      <= '0;
      opnd_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halt      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ac_q      <= ac_d;
      ir_q      <= ir_d;
      opnd_q    <= opnd_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      halt      <= halt_d;
    end
  end

`ifdef RISC_CORE_HS_PERF_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 16'd1;
  end

  assign instr_cnt = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign instr_cnt     = '0;
`endif

endmodule

// File: tb/tb_risc_core_hs.sv
// Scoreboard bench for risc_core_hs: an ISA-level interpreter predicts the memory
// transaction stream, halt timing, final memory image and retired count.
module tb_risc_core_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_req, mem_we, mem_ack, halt;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [15:0] instr_cnt;

  risc_core_hs dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halt      (halt),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit we;
    int addr;
    int wdata;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] mem [32];
  logic [7:0] img [32];
  int         rm [32];
  int         waits = 0;
  int         wcnt;
  int         checks = 0;
  int         errors = 0;
  bit         sb_strict = 0;
  bit         exp_halt;
  int         exp_cycles, exp_cnt;

  // Memory with programmable wait states; ack is combinational once the count is met.
  assign mem_ack   = mem_req && (wcnt == waits);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (mem_req && mem_ack) begin
      wcnt <= 0;
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end else if (mem_req) wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Monitor: pops expected transactions on each handshake, checks hold and spacing rules.
  bit         prev_pend = 0, post_hs = 0;
  logic       p_we;
  logic [4:0] p_addr;
  logic [7:0] p_wdata;
  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      prev_pend = 0;
      post_hs   = 0;
    end else begin
      if (post_hs) begin
        checks++;
        if (mem_req) begin
          errors++;
          $display("FAIL back_to_back: mem_req=%0b required 0", mem_req);
        end
      end
      if (prev_pend) begin
        checks++;
        if (!mem_req || mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wdata) begin
          errors++;
          $display("FAIL req_hold: req=%0b we=%0b addr=%0h wdata=%0h required 1 %0b %0h %0h",
                   mem_req, mem_we, mem_addr, mem_wdata, p_we, p_addr, p_wdata);
        end
      end
      post_hs   = mem_req && mem_ack;
      prev_pend = mem_req && !mem_ack;
      p_we      = mem_we;
      p_addr    = mem_addr;
      p_wdata   = mem_wdata;
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          if (sb_strict) begin
            checks++;
            errors++;
            $display("FAIL extra_txn: we=%0b addr=%0h required none", mem_we, mem_addr);
          end
        end else begin
          t = exp_q.pop_front();
          checks++;
          if (mem_we !== t.we || int'(mem_addr) != t.addr || (t.we && int'(mem_wdata) != t.wdata)) begin
            errors++;
            $display("FAIL txn: we=%0b addr=%0h wdata=%0h required we=%0b addr=%0h wdata=%0h",
                     mem_we, mem_addr, mem_wdata, t.we, t.addr, t.wdata);
          end
        end
      end
    end
  end

  // Instruction-level interpreter: whole instructions, no sequencer states.
  task automatic model(input int w, input int max_steps);
    int pc, ac, ir, op, a;
    bit done;
    exp_q.delete();
    exp_halt = 0; exp_cycles = 0; exp_cnt = 0;
    pc = 0; ac = 0; done = 0;
    for (int s = 0; s < max_steps && !done; s++) begin
      ir = rm[pc];
      exp_q.push_back('{1'b0, pc, 0});
      exp_cycles += 4 + w;
      pc = (pc + 1) % 32;
      op = ir / 32;
      a  = ir % 32;
      exp_cnt++;
      if (op >= 2 && op <= 6) begin
        exp_cycles += 2 + w;
        if (op == 6) begin
          exp_q.push_back('{1'b1, a, ac});
          rm[a] = ac;
        end else exp_q.push_back('{1'b0, a, 0});
      end
      case (op)
        0: begin exp_halt = 1; done = 1; end
        1: if (ac == 0) pc = (pc + 1) % 32;
        2: ac = (ac + rm[a]) % 256;
        3: ac = ac & rm[a];
        4: ac = ac ^ rm[a];
        5: ac = rm[a];
        7: pc = a;
        default: ;
      endcase
    end
  endtask

  task automatic load_image();
    for (int i = 0; i < 32; i++) begin
      mem[i] = img[i];
      rm[i]  = int'(img[i]);
    end
  endtask

  task automatic run_prog(input int w, input int max_steps, input string name);
    int cyc;
    int bad;
    int ecnt;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    load_image();
    waits = w;
    model(w, max_steps);
    sb_strict = exp_halt;
`ifdef RISC_CORE_HS_PERF_EN
    ecnt = exp_cnt % 65536;
`else
    ecnt = 0;
`endif
    @(negedge clk) rst = 1'b1;
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_halt ? (halt === 1'b1) : (exp_q.size() == 0)) break;
    end
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no completion after %0d cycles", name, cyc);
    end else if (exp_halt) begin
      chk({name, "_cycles"}, cyc, exp_cycles);
      chk({name, "_instr_cnt"}, int'(instr_cnt), ecnt);
      repeat (4) @(negedge clk);
      chk({name, "_halted_idle"}, {30'd0, halt, mem_req}, 2);
      chk({name, "_txn_left"}, exp_q.size(), 0);
      bad = 0;
      for (int i = 0; i < 32; i++) if (int'(mem[i]) != rm[i]) bad++;
      chk({name, "_mem_image"}, bad, 0);
    end
    sb_strict = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_halt", int'(halt), 0);
    chk("rst_instr_cnt", int'(instr_cnt), 0);

    // Lone HLT at address 0.
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    run_prog(0, 10, "hlt_only");

    // LDA 10; ADD 11; STO 12; HLT with an 8-bit wrap.
    img[0] = 8'hAA; img[1] = 8'h4B; img[2] = 8'hCC; img[3] = 8'h00;
    img[10] = 8'hF0; img[11] = 8'h20; img[12] = 8'h00;
    run_prog(0, 10, "add_wrap");
    chk("add_wrap_m12", int'(mem[12]), 8'h10);
    run_prog(3, 10, "add_wrap_w3");
    chk("add_wrap_w3_m12", int'(mem[12]), 8'h10);

    // SKZ with AC zero skips the JMP; with AC nonzero the loop is taken.
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0] = 8'hAA; img[1] = 8'h20; img[2] = 8'hE0; img[3] = 8'h00;
    run_prog(0, 10, "skz_zero");
    img[10] = 8'h05;
    run_prog(1, 9, "skz_nonzero");

    // PC wrap: SKZ at 30 skips 31 and wraps; JMP 31 then increments to 0.
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0] = 8'hFE; img[30] = 8'h20; img[31] = 8'h00;
    run_prog(0, 6, "skz_wrap");
    img[0] = 8'hFF; img[31] = 8'hBD; img[29] = 8'h33;
    run_prog(0, 6, "pc_wrap");

    // Reset while the STO write is pending.
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    img[0] = 8'hAA; img[1] = 8'hCC; img[2] = 8'h00;
    img[10] = 8'h37; img[12] = 8'h55;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    load_image();
    waits = 6;
    model(6, 2);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) break;
    end
    chk("sto_pending_addr", {26'd0, mem_we, mem_addr}, 32'h2C);
    chk("sto_pending_wdata", int'(mem_wdata), 8'h37);
    #1 rst = 1'b0;
    #1;
    chk("abort_req_drop", int'(mem_req), 0);
    chk("abort_txn_left", exp_q.size(), 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_write", int'(mem[12]), 8'h55);
    run_prog(0, 10, "after_abort");
    chk("after_abort_m12", int'(mem[12]), 8'h37);

    // Random images with random wait states.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom_range(0, 255));
      run_prog(int'($urandom_range(0, 2)), 40, "random");
    end

    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
